peltier_regulator: RTL and testbench
====================================

# peltier_regulator

Closed-loop temperature regulator for the CCD cold stage. Every `PERIOD` clock cycles it requests one MCP3008 conversion and captures the result by passively tapping the existing MCP data handshake. It then runs a saturating proportional-integral update against a host setpoint and drives an 8-bit Peltier duty cycle. The block sits between the MCP3008 interface / tx_mux pair and the Peltier PWM comparator, and replaces the fixed host-written duty register when regulation is enabled.

## Interface
- `PERIOD`, 1_000_000: clock cycles between sample requests (10 ms at 100 MHz).
- `TIMEOUT`, 65_536: cycles allowed from request to captured sample.
- `KP_SHIFT`, 2: proportional gain, applied as a left shift.
- `KI_SHIFT`, 6: integral gain, applied as an arithmetic right shift.
- `INT_W`, 16: integrator width, signed.

- `clk`  in  1: system clock, 100 MHz.
- `rst`  in  1: synchronous, active-high reset.
- `enable`  in  1: regulation on; low forces idle.
- `setpoint`  in  10: target ADC code.
- `adc_busy`  in  1: MCP interface busy.
- `adc_data`  in  16: MCP output word; conversion result in [9:0].
- `adc_avail`  in  1: MCP data available.
- `adc_accepted`  in  1: tx_mux accept for the MCP channel, monitored only.
- `sample_req`  out  1: OR'd into the MCP sample toggle.
- `duty`  out  8: Peltier duty cycle.
- `integ`  out  INT_W: integrator value, for debug.
- `fault`  out  1: sticky sample-timeout flag.

## Operation
- Reset values: `duty`=0, `integ`=0, `fault`=0, `sample_req`=0, state IDLE, tick counter 0.
- States and transitions:
  - IDLE: all outputs held at reset values; tick counter cleared. Goes to WAIT_TICK when `enable`=1.
  - WAIT_TICK: counter counts to `PERIOD`-1. At terminal count, goes to REQ if `adc_busy`=0; otherwise holds at terminal count and retries every cycle.
  - REQ: `sample_req`=1 for exactly 2 cycles, then goes to WAIT_DATA. The timeout counter is cleared on entry.
  - WAIT_DATA: captures `s`=`adc_data[9:0]` on the first cycle with `adc_avail`&&`adc_accepted`, then goes to ERR. If `TIMEOUT` cycles elapse first: `fault`=1, `duty`=0, integrator unchanged, go to WAIT_TICK.
  - ERR: e = s − setpoint, 11-bit signed. A higher ADC code means a warmer stage.
  - INTEG: integrator updates as integ + e, saturated to the signed INT_W range. Anti-windup freezes the integrator when previous `duty`=255 and e>0, or previous `duty`=0 and e<0.
  - OUT: u = (e <<< KP_SHIFT) + (integ_new >>> KI_SHIFT), computed at INT_W+4 bits signed. `duty` = clamp(u, 0, 255). Goes to WAIT_TICK with the counter restarted.
- `enable` falling in any state: on the next cycle the block is in IDLE, `duty`=0, integrator cleared, `fault` cleared, `sample_req`=0. An MCP conversion already in flight completes and goes to tx_mux untouched.
- Conversions requested by the host (not by this block) are ignored: capture happens only in WAIT_DATA.
- A valid capture does not clear `fault`. Only `rst` or `enable` low clears it.
- `setpoint` is sampled in ERR only, so changes mid-cycle take effect on the next sample.

## Timing
- The first request is issued `PERIOD`+1 cycles after `enable` rises, with `adc_busy`=0.
- Capture cycle to `duty` update: 3 cycles (ERR, INTEG, OUT). `duty` is registered and valid on the cycle after OUT.
- `rst` asserted mid-operation: all state returns to reset values on the next edge.
- Tick counter wrap: the counter restarts only on leaving OUT, on a timeout, or on IDLE. It never free-runs past terminal count.
- If `adc_avail`&&`adc_accepted` coincides with the timeout cycle, the capture wins and no fault is raised.

## Structure
- Add to `controller.vh`:
  - the state encodings (gray-style 3-bit codes, in keeping with the top-level FSM);
  - `cmd_set_reg2` bit 2 as the regulation enable;
  - `fpga_reg[3]`/`fpga_reg[4]` as the setpoint MSB/LSB.
- Sub-module `pi_step`: purely combinational e / integ_new / duty arithmetic with saturation. It is instantiated once and unit-testable separately.
- Top-level integration: `pwm_peltier_1` uses `duty` when enabled, otherwise `fpga_reg[0]`.

## Test plan
All scenarios use `PERIOD`=16, `TIMEOUT`=64, `setpoint`=500.
- Sample 520 → e=20, `integ`=20, `duty`=80 three cycles after capture. A second sample 520 → `integ`=40, `duty`=80.
- Sample 600 → `duty`=255. Sample 600 again → `integ` frozen at its prior value (anti-windup).
- Sample 480 from reset → `duty`=0, `integ` stays 0. Check the integrator also saturates at +32767 after repeated sample 1023 with `KP_SHIFT`=0 and `duty` forced unsaturated via `KI_SHIFT`=15.
- Never assert `adc_avail` → `fault`=1 and `duty`=0 exactly 64 cycles after REQ ends. The next request follows 16 cycles later. `enable` low clears `fault`.
- `adc_busy` held high at terminal count for 5 cycles → `sample_req` rises on the cycle after `adc_busy` falls, 2 cycles wide. A host-triggered sample during WAIT_TICK is not captured.
- `enable` dropped while in INTEG → next cycle IDLE, `duty`=0, `integ`=0. `rst` mid-WAIT_DATA → all outputs at reset values.

Source files
------------

// File: rtl/peltier_regulator_pkg.sv
// Shared widths, FSM state codes and helper arithmetic for the Peltier
// cold-stage regulator and its PI arithmetic core.
package peltier_regulator_pkg;

  localparam int SAMPLE_W = 10;
  localparam int ERR_W    = 11;
  localparam int DUTY_W   = 8;

  // Gray-style 3-bit state codes: each step of the normal sampling loop
  // changes a single bit.
  localparam logic [2:0] ST_IDLE      = 3'b000;
  localparam logic [2:0] ST_WAIT_TICK = 3'b001;
  localparam logic [2:0] ST_REQ       = 3'b011;
  localparam logic [2:0] ST_WAIT_DATA = 3'b010;
  localparam logic [2:0] ST_ERR       = 3'b110;
  localparam logic [2:0] ST_INTEG     = 3'b111;
  localparam logic [2:0] ST_OUT       = 3'b101;

  // Signed error between an unsigned ADC code and the unsigned setpoint.
  // Both are zero-extended by one bit, so the 11-bit result cannot overflow.
  // A positive error means the stage is warmer than the target.
  function automatic logic signed [ERR_W-1:0] sample_error(
    input logic [SAMPLE_W-1:0] s,
    input logic [SAMPLE_W-1:0] sp
  );
    return $signed({1'b0, s}) - $signed({1'b0, sp});
  endfunction

endpackage

// File: rtl/peltier_regulator_pi_step.sv
// Purely combinational PI arithmetic: error, saturated integrator update
// with anti-windup, and clamped 8-bit duty. The FSM in the top picks which
// result to register in which state.
module pi_step
  import peltier_regulator_pkg::*;
#(
  parameter int KP_SHIFT = 2,
  parameter int KI_SHIFT = 6,
  parameter int INT_W    = 16
) (
  input  logic        [SAMPLE_W-1:0] sample,
  input  logic        [SAMPLE_W-1:0] setpoint,
  input  logic signed [ERR_W-1:0]    err_in,
  input  logic signed [INT_W-1:0]    integ_in,
  input  logic        [DUTY_W-1:0]   duty_in,
  output logic signed [ERR_W-1:0]    err,
  output logic signed [INT_W-1:0]    integ_next,
  output logic        [DUTY_W-1:0]   duty_next
);

  localparam int SUM_W = INT_W + 1;
  localparam int UW    = INT_W + 4;

  localparam logic signed [SUM_W-1:0] INT_MAX = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] INT_MIN = {2'b11, {(INT_W-1){1'b0}}};

  logic signed [SUM_W-1:0] sum;
  logic                    err_pos;
  logic                    freeze;
  logic signed [UW-1:0]    e_ext;
  logic signed [UW-1:0]    i_ext;
  logic signed [UW-1:0]    p_term;
  logic signed [UW-1:0]    i_term;
  logic signed [UW-1:0]    u;

  // Error, integrator update and duty are all derived in one block; the
  // integrator is frozen when the previous duty is already pinned at the
  // rail the error would push it further into.
  always_comb begin
    err = sample_error(sample, setpoint);

    sum = {integ_in[INT_W-1], integ_in}
        + {{(SUM_W-ERR_W){err_in[ERR_W-1]}}, err_in};

    err_pos = !err_in[ERR_W-1] && (err_in != '0);
    freeze  = ((duty_in == {DUTY_W{1'b1}}) && err_pos) ||
              ((duty_in == '0) && err_in[ERR_W-1]);

    if (freeze)
      integ_next = integ_in;
    else if (sum > INT_MAX)
      integ_next = INT_MAX[INT_W-1:0];
    else if (sum < INT_MIN)
      integ_next = INT_MIN[INT_W-1:0];
    else
      integ_next = sum[INT_W-1:0];

    e_ext  = {{(UW-ERR_W){err_in[ERR_W-1]}}, err_in};
    i_ext  = {{(UW-INT_W){integ_in[INT_W-1]}}, integ_in};
    p_term = e_ext <<< KP_SHIFT;
    i_term = i_ext >>> KI_SHIFT;
    u      = p_term + i_term;

    if (u[UW-1])
      duty_next = '0;
    else if (|u[UW-2:DUTY_W])
      duty_next = {DUTY_W{1'b1}};
    else
      duty_next = u[DUTY_W-1:0];
  end

endmodule

// File: rtl/peltier_regulator.sv
// Closed-loop Peltier regulator: periodically requests an MCP3008
// conversion, taps the MCP data handshake for the result, and runs a
// saturating PI update to produce the Peltier duty cycle.
module peltier_regulator
  import peltier_regulator_pkg::*;
#(
  parameter int PERIOD   = 1_000_000,
  parameter int TIMEOUT  = 65_536,
  parameter int KP_SHIFT = 2,
  parameter int KI_SHIFT = 6,
  parameter int INT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [SAMPLE_W-1:0]     setpoint,
  input  logic                    adc_busy,
  input  logic [15:0]             adc_data,
  input  logic                    adc_avail,
  input  logic                    adc_accepted,
  output logic                    sample_req,
  output logic [DUTY_W-1:0]       duty,
  output logic signed [INT_W-1:0] integ,
  output logic                    fault
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]               state;
  logic [CNT_W-1:0]         tick_cnt;
  logic [TO_W-1:0]          to_cnt;
  logic                     req_cnt;
  logic [SAMPLE_W-1:0]      sample_q;
  logic signed [ERR_W-1:0]  err_q;

  logic signed [ERR_W-1:0]  err_w;
  logic signed [INT_W-1:0]  integ_w;
  logic [DUTY_W-1:0]        duty_w;

  // Upper MCP word bits carry framing only; the conversion is in [9:0].
  logic unused_adc_bits;
  assign unused_adc_bits = &{1'b0, adc_data[15:SAMPLE_W]};

  assign sample_req = (state == ST_REQ);

  pi_step #(
    .KP_SHIFT(KP_SHIFT),
    .KI_SHIFT(KI_SHIFT),
    .INT_W   (INT_W)
  ) u_pi_step (
    .sample    (sample_q),
    .setpoint  (setpoint),
    .err_in    (err_q),
    .integ_in  (integ),
    .duty_in   (duty),
    .err       (err_w),
    .integ_next(integ_w),
    .duty_next (duty_w)
  );

  // Sampling FSM: tick, request, capture, then three register stages for
  // error, integrator and duty. Reset and a low enable both force idle.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      to_cnt   <= '0;
      req_cnt  <= 1'b0;
      sample_q <= '0;
      err_q    <= '0;
      duty     <= '0;
      integ    <= '0;
      fault    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tick_cnt <= '0;
          state    <= ST_WAIT_TICK;
        end
        ST_WAIT_TICK: begin
          if (tick_cnt == CNT_W'(PERIOD - 1)) begin
            if (!adc_busy) begin
              req_cnt <= 1'b0;
              to_cnt  <= '0;
              state   <= ST_REQ;
            end
          end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
          end
        end
        ST_REQ: begin
          to_cnt <= '0;
          if (req_cnt)
            state <= ST_WAIT_DATA;
          else
            req_cnt <= 1'b1;
        end
        ST_WAIT_DATA: begin
          if (adc_avail && adc_accepted) begin
            sample_q <= adc_data[SAMPLE_W-1:0];
            state    <= ST_ERR;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            fault    <= 1'b1;
            duty     <= '0;
            tick_cnt <= '0;
            state    <= ST_WAIT_TICK;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_ERR: begin
          err_q <= err_w;
          state <= ST_INTEG;
        end
        ST_INTEG: begin
          integ <= integ_w;
          state <= ST_OUT;
        end
        ST_OUT: begin
          duty     <= duty_w;
          tick_cnt <= '0;
          state    <= ST_WAIT_TICK;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peltier_regulator.sv
// Directed scoreboard bench for peltier_regulator with PERIOD=16,
// TIMEOUT=64, setpoint=500, plus direct checks of pi_step saturation.
module tb_peltier_regulator;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [9:0]        setpoint;
  logic              adc_busy;
  logic [15:0]       adc_data;
  logic              adc_avail;
  logic              adc_accepted;
  logic              sample_req;
  logic [7:0]        duty;
  logic signed [15:0] integ;
  logic              fault;

  logic [9:0]         ut_sample;
  logic [9:0]         ut_setpoint;
  logic signed [10:0] ut_err_in;
  logic signed [15:0] ut_integ_in;
  logic [7:0]         ut_duty_in;
  logic signed [10:0] ut_err;
  logic signed [15:0] ut_integ_next;
  logic [7:0]         ut_duty_next;

  typedef struct {
    string              name;
    int                 due;
    logic [7:0]         duty;
    logic signed [15:0] integ;
    logic               fault;
    logic               req;
  } exp_t;

  exp_t exp_q[$];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic [7:0]         m_duty;
  logic signed [15:0] m_integ;
  logic               m_fault;

  peltier_regulator #(
    .PERIOD  (16),
    .TIMEOUT (64),
    .KP_SHIFT(2),
    .KI_SHIFT(6),
    .INT_W   (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .setpoint    (setpoint),
    .adc_busy    (adc_busy),
    .adc_data    (adc_data),
    .adc_avail   (adc_avail),
    .adc_accepted(adc_accepted),
    .sample_req  (sample_req),
    .duty        (duty),
    .integ       (integ),
    .fault       (fault)
  );

  pi_step #(
    .KP_SHIFT(0),
    .KI_SHIFT(15),
    .INT_W   (16)
  ) ut_pi (
    .sample    (ut_sample),
    .setpoint  (ut_setpoint),
    .err_in    (ut_err_in),
    .integ_in  (ut_integ_in),
    .duty_in   (ut_duty_in),
    .err       (ut_err),
    .integ_next(ut_integ_next),
    .duty_next (ut_duty_next)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Cycle index: number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case a wait ever escapes its bound
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // Monitor: just after each falling edge, compare DUT outputs against every
  // expectation due on this cycle
  initial begin
    exp_t item;
    forever begin
      @(negedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        item = exp_q.pop_front();
        checks++;
        if (item.due != cyc || duty !== item.duty || integ !== item.integ ||
            fault !== item.fault || sample_req !== item.req) begin
          errors++;
          $display("[TB] FAIL %s cyc=%0d due=%0d got duty=%0d integ=%0d fault=%0b req=%0b want duty=%0d integ=%0d fault=%0b req=%0b",
                   item.name, cyc, item.due, duty, integ, fault, sample_req,
                   item.duty, item.integ, item.fault, item.req);
        end
      end
    end
  end

  task automatic pushExp(input string name, input int due, input logic [7:0] d,
                         input logic signed [15:0] i, input logic f, input logic r);
    exp_t item;
    item.name  = name;
    item.due   = due;
    item.duty  = d;
    item.integ = i;
    item.fault = f;
    item.req   = r;
    exp_q.push_back(item);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s got %0d want %0d", name, actual, expected);
    end
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic waitLevel(input logic level, input string what);
    int n;
    n = 0;
    while (sample_req !== level && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sample_req !== level) begin
      errors++;
      $display("[TB] FAIL %s sample_req got %b want %b", what, sample_req, level);
    end
  endtask

  task automatic pulseCapture(input logic [9:0] s);
    adc_data     = {6'b0, s};
    adc_avail    = 1'b1;
    adc_accepted = 1'b1;
    @(negedge clk);
    adc_avail    = 1'b0;
    adc_accepted = 1'b0;
  endtask

  // Wait for the next request, deliver one sample on the first WAIT_DATA
  // cycle and expect the new duty/integ three edges after the capture edge
  task automatic applyStimulus(input string name, input logic [9:0] s,
                               input logic [7:0] exp_duty, input logic signed [15:0] exp_integ);
    int due;
    waitLevel(1'b1, {name, "_req_hi"});
    waitLevel(1'b0, {name, "_req_lo"});
    due = cyc + 4;
    pushExp(name, due, exp_duty, exp_integ, m_fault, 1'b0);
    pulseCapture(s);
    waitUntil(due);
    m_duty  = exp_duty;
    m_integ = exp_integ;
  endtask

  // Stimulus: directed sequence with hand-computed expectations
  initial begin
    int k;
    int w;
    rst = 1'b1; enable = 1'b0; setpoint = 10'd500; adc_busy = 1'b0;
    adc_data = '0; adc_avail = 1'b0; adc_accepted = 1'b0;
    ut_sample = '0; ut_setpoint = '0; ut_err_in = '0; ut_integ_in = '0; ut_duty_in = '0;
    m_duty = 8'd0; m_integ = 16'sd0; m_fault = 1'b0;

    repeat (3) @(negedge clk);
    pushExp("reset", cyc, 8'd0, 16'sd0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // First request PERIOD+1 edges after enable is seen, two cycles wide
    k = cyc;
    enable = 1'b1;
    pushExp("first_req_pre", k + 16, 8'd0, 16'sd0, 1'b0, 1'b0);
    pushExp("first_req_1",   k + 17, 8'd0, 16'sd0, 1'b0, 1'b1);
    pushExp("first_req_2",   k + 18, 8'd0, 16'sd0, 1'b0, 1'b1);
    pushExp("first_req_end", k + 19, 8'd0, 16'sd0, 1'b0, 1'b0);
    applyStimulus("s480_from_reset", 10'd480, 8'd0,   16'sd0);
    applyStimulus("s520_a",          10'd520, 8'd80,  16'sd20);
    applyStimulus("s520_b",          10'd520, 8'd80,  16'sd40);
    applyStimulus("s600_a",          10'd600, 8'd255, 16'sd140);
    applyStimulus("s600_windup",     10'd600, 8'd255, 16'sd140);
    applyStimulus("s400_neg",        10'd400, 8'd0,   16'sd40);
    applyStimulus("s510",            10'd510, 8'd40,  16'sd50);
    applyStimulus("s530_iterm",      10'd530, 8'd121, 16'sd80);

    // adc_busy holds the request off at terminal count; a host conversion
    // during WAIT_TICK is ignored
    k = cyc;
    adc_busy = 1'b1;
    waitUntil(k + 5);
    pulseCapture(10'd1023);
    pushExp("host_sample_ignored", k + 7,  m_duty, m_integ, 1'b0, 1'b0);
    pushExp("busy_hold",           k + 20, m_duty, m_integ, 1'b0, 1'b0);
    pushExp("busy_req_1",          k + 21, m_duty, m_integ, 1'b0, 1'b1);
    pushExp("busy_req_2",          k + 22, m_duty, m_integ, 1'b0, 1'b1);
    pushExp("busy_req_end",        k + 23, m_duty, m_integ, 1'b0, 1'b0);
    waitUntil(k + 20);
    adc_busy = 1'b0;
    applyStimulus("s520_after_busy", 10'd520, 8'd81, 16'sd100);

    // Capture on the timeout cycle wins over the fault
    waitLevel(1'b1, "tocap_req_hi");
    waitLevel(1'b0, "tocap_req_lo");
    w = cyc;
    waitUntil(w + 63);
    pushExp("capture_on_timeout", w + 67, 8'd1, 16'sd100, 1'b0, 1'b0);
    pulseCapture(10'd500);
    waitUntil(w + 67);
    m_duty = 8'd1; m_integ = 16'sd100;

    // Enable dropped while the FSM sits in INTEG
    waitLevel(1'b1, "endrop_req_hi");
    waitLevel(1'b0, "endrop_req_lo");
    k = cyc;
    pulseCapture(10'd520);
    waitUntil(k + 2);
    enable = 1'b0;
    pushExp("enable_drop_integ", k + 3, 8'd0, 16'sd0, 1'b0, 1'b0);
    waitUntil(k + 3);
    m_duty = 8'd0; m_integ = 16'sd0;
    enable = 1'b1;
    applyStimulus("s520_after_drop", 10'd520, 8'd80, 16'sd20);

    // Sample timeout: fault and duty 0 after 64 WAIT_DATA cycles, next
    // request 16 cycles later, fault survives a good capture
    waitLevel(1'b1, "to_req_hi");
    waitLevel(1'b0, "to_req_lo");
    w = cyc;
    pushExp("timeout_pre",  w + 63, 8'd80, 16'sd20, 1'b0, 1'b0);
    pushExp("timeout",      w + 64, 8'd0,  16'sd20, 1'b1, 1'b0);
    pushExp("to_next_pre",  w + 79, 8'd0,  16'sd20, 1'b1, 1'b0);
    pushExp("to_next_req",  w + 80, 8'd0,  16'sd20, 1'b1, 1'b1);
    waitUntil(w + 64);
    m_duty = 8'd0; m_fault = 1'b1;
    applyStimulus("s520_fault_sticky", 10'd520, 8'd80, 16'sd40);

    // enable low clears the sticky fault
    k = cyc;
    enable = 1'b0;
    pushExp("enable_clears_fault", k + 1, 8'd0, 16'sd0, 1'b0, 1'b0);
    waitUntil(k + 1);
    m_duty = 8'd0; m_integ = 16'sd0; m_fault = 1'b0;
    enable = 1'b1;
    applyStimulus("s520_restart", 10'd520, 8'd80, 16'sd20);

    // rst in the middle of WAIT_DATA
    waitLevel(1'b1, "rst_req_hi");
    waitLevel(1'b0, "rst_req_lo");
    w = cyc;
    rst = 1'b1;
    pushExp("rst_mid_wait_data", w + 1, 8'd0, 16'sd0, 1'b0, 1'b0);
    waitUntil(w + 1);
    rst = 1'b0;
    waitUntil(w + 4);

    // pi_step alone with KP_SHIFT=0, KI_SHIFT=15
    ut_sample = 10'd1023; ut_setpoint = 10'd500; #1;
    checkOutput("pi_err_1023", int'(ut_err), 523);
    ut_err_in = 11'sd523; ut_integ_in = 16'sd32700; ut_duty_in = 8'd100; #1;
    checkOutput("pi_sat_pos", int'(ut_integ_next), 32767);
    ut_err_in = -11'sd100; ut_integ_in = -16'sd32760; ut_duty_in = 8'd100; #1;
    checkOutput("pi_sat_neg", int'(ut_integ_next), -32768);
    ut_err_in = 11'sd5; ut_integ_in = 16'sd1000; ut_duty_in = 8'd255; #1;
    checkOutput("pi_windup_hi", int'(ut_integ_next), 1000);
    ut_err_in = -11'sd3; ut_integ_in = 16'sd32767; ut_duty_in = 8'd100; #1;
    checkOutput("pi_duty_clamp_lo", int'(ut_duty_next), 0);
    ut_err_in = 11'sd200; ut_integ_in = -16'sd32768; ut_duty_in = 8'd100; #1;
    checkOutput("pi_duty_ashr", int'(ut_duty_next), 199);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
